// File: rtl/axi_multi_port_bridge_if.sv
// Request/response ports and AXI3 master channels of the multi-port bridge.
// The master modport is the bridge's view; the slave modport is the requesters' and memory's view.
interface axi_multi_port_bridge_if #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ID_W      = 4
);
    logic [NUM_PORTS-1:0]          req_valid;
    logic [NUM_PORTS-1:0]          req_ready;
    logic [NUM_PORTS-1:0]          req_wr;
    logic [NUM_PORTS*ADDR_W-1:0]   req_addr;
    logic [NUM_PORTS*8-1:0]        req_len;
    logic [NUM_PORTS*3-1:0]        req_size;
    logic [NUM_PORTS*DATA_W-1:0]   req_wdata;
    logic [NUM_PORTS*DATA_W/8-1:0] req_wstrb;
    logic [NUM_PORTS-1:0]          rsp_rvalid;
    logic [DATA_W-1:0]             rsp_rdata;
    logic                          rsp_rlast;
    logic [NUM_PORTS-1:0]          rsp_wdone;
    logic                          rsp_err;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        input  req_valid, req_wr, req_addr, req_len, req_size, req_wdata, req_wstrb,
        output req_ready, rsp_rvalid, rsp_rdata, rsp_rlast, rsp_wdone, rsp_err,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_len, req_size, req_wdata, req_wstrb,
        input  req_ready, rsp_rvalid, rsp_rdata, rsp_rlast, rsp_wdone, rsp_err,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_multi_port_bridge.sv
// Round-robin bridge from NUM_PORTS request ports to one AXI3 master: one read burst
// and one single-beat write in flight, with reads to a pending write's word held back.
module axi_multi_port_bridge #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned MAX_LEN   = 8
) (
    input logic                     aclk,
    input logic                     aresetn,
    axi_multi_port_bridge_if.master bus
);
    localparam int unsigned PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic [7:0]  LEN_CAP = 8'(MAX_LEN - 1);

    typedef enum logic [1:0] {RIdle, RAr, RData} r_state_e;
    typedef enum logic [1:0] {WIdle, WSend, WResp} w_state_e;

    r_state_e          r_state_q;
    w_state_e          w_state_q;
    logic [PTR_W-1:0]  rr_ptr_q;

    logic [ADDR_W-1:0] r_addr_q;
    logic [7:0]        r_len_q;
    logic [2:0]        r_size_q;
    logic [ID_W-1:0]   r_id_q;
    logic              arvalid_q, rready_q;

    logic [ADDR_W-1:0] w_addr_q;
    logic [2:0]        w_size_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic [ID_W-1:0]   w_id_q;
    logic              awvalid_q, wvalid_q, bready_q;

    logic [NUM_PORTS-1:0] hazard, eligible, grant;
    logic                 grant_any;
    logic [PTR_W-1:0]     grant_idx;
    logic                 g_wr;
    logic [ADDR_W-1:0]    g_addr;
    logic [7:0]           g_len;
    logic [2:0]           g_size;
    logic [DATA_W-1:0]    g_wdata;
    logic [STRB_W-1:0]    g_wstrb;
    logic                 r_beat, b_beat;

    // Eligibility is forced low during reset so no grant is visible while aresetn is asserted.
    always_comb begin
        hazard   = '0;
        eligible = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            hazard[i] = (w_state_q != WIdle) &&
                        (bus.req_addr[i*ADDR_W+2 +: ADDR_W-2] == w_addr_q[ADDR_W-1:2]);
            eligible[i] = aresetn && bus.req_valid[i] &&
                          (bus.req_wr[i] ? (w_state_q == WIdle)
                                         : ((r_state_q == RIdle) && !hazard[i]));
        end
    end

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant     = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (!grant_any && eligible[i] && (i == (32'(rr_ptr_q) + k) % NUM_PORTS)) begin
                    grant_any = 1'b1;
                    grant_idx = PTR_W'(i);
                    grant[i]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        g_wr    = 1'b0;
        g_addr  = '0;
        g_len   = '0;
        g_size  = '0;
        g_wdata = '0;
        g_wstrb = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                g_wr    = bus.req_wr[i];
                g_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                g_len   = bus.req_len[i*8 +: 8];
                g_size  = bus.req_size[i*3 +: 3];
                g_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
                g_wstrb = bus.req_wstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= RIdle;
            w_state_q <= WIdle;
            rr_ptr_q  <= PTR_W'(NUM_PORTS - 1);
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_id_q    <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            w_addr_q  <= '0;
            w_size_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            w_id_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            if (grant_any) rr_ptr_q <= grant_idx;

            case (r_state_q)
                RIdle: if (grant_any && !g_wr) begin
                    r_addr_q  <= g_addr;
                    r_size_q  <= g_size;
                    r_len_q   <= (g_len > LEN_CAP) ? LEN_CAP : g_len;
                    r_id_q    <= ID_W'(grant_idx);
                    arvalid_q <= 1'b1;
                    r_state_q <= RAr;
                end
                RAr: if (bus.arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    r_state_q <= RData;
                end
                RData: if (bus.rvalid && bus.rlast) begin
                    rready_q  <= 1'b0;
                    r_state_q <= RIdle;
                end
                default: r_state_q <= RIdle;
            endcase

            case (w_state_q)
                WIdle: if (grant_any && g_wr) begin
                    w_addr_q  <= g_addr;
                    w_size_q  <= g_size;
                    w_data_q  <= g_wdata;
                    w_strb_q  <= g_wstrb;
                    w_id_q    <= ID_W'(grant_idx);
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                    w_state_q <= WSend;
                end
                WSend: begin
                    if (bus.awready) awvalid_q <= 1'b0;
                    if (bus.wready)  wvalid_q  <= 1'b0;
                    // Both channels done, whether together or in either order.
                    if ((!awvalid_q || bus.awready) && (!wvalid_q || bus.wready)) begin
                        bready_q  <= 1'b1;
                        w_state_q <= WResp;
                    end
                end
                WResp: if (bus.bvalid) begin
                    bready_q  <= 1'b0;
                    w_state_q <= WIdle;
                end
                default: w_state_q <= WIdle;
            endcase
        end
    end

    assign r_beat = (r_state_q == RData) && bus.rvalid;
    assign b_beat = (w_state_q == WResp) && bus.bvalid;

    // Beats go to the port named by rid; a foreign rid is still routed but flagged.
    always_comb begin
        bus.rsp_rvalid = '0;
        bus.rsp_wdone  = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            bus.rsp_rvalid[i] = r_beat && (32'(bus.rid) == i);
            bus.rsp_wdone[i]  = b_beat && (32'(bus.bid) == i);
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_rdata = bus.rdata;
    assign bus.rsp_rlast = r_beat && bus.rlast;
    assign bus.rsp_err   = (r_beat && ((bus.rresp != 2'b00) || (bus.rid != r_id_q))) ||
                           (b_beat && (bus.bresp != 2'b00));

    assign bus.arid    = r_id_q;
    assign bus.araddr  = r_addr_q;
    assign bus.arlen   = r_len_q;
    assign bus.arsize  = r_size_q;
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'b0000;
    assign bus.arprot  = 3'b000;
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = rready_q;

    assign bus.awid    = w_id_q;
    assign bus.awaddr  = w_addr_q;
    assign bus.awlen   = 8'd0;
    assign bus.awsize  = w_size_q;
    assign bus.awburst = 2'b01;
    assign bus.awlock  = 2'b00;
    assign bus.awcache = 4'b0000;
    assign bus.awprot  = 3'b000;
    assign bus.awvalid = awvalid_q;
    assign bus.wid     = w_id_q;
    assign bus.wdata   = w_data_q;
    assign bus.wstrb   = w_strb_q;
    assign bus.wlast   = 1'b1;
    assign bus.wvalid  = wvalid_q;
    assign bus.bready  = bready_q;
endmodule

// File: tb/tb_axi_multi_port_bridge.sv
// Directed and randomized bench for axi_multi_port_bridge; the AXI slave and the expected
// responses are modelled in the bench from the request fields alone.
module tb_axi_multi_port_bridge;
    localparam int unsigned NP = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 4;
    localparam int unsigned ML = 8;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    axi_multi_port_bridge_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus ();

    axi_multi_port_bridge #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_LEN(ML)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_passed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Memory contents as seen by the slave: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
    endfunction

    task automatic wait_grant(input int p, input string tag);
        int n = 0;
        #1;
        while (!bus.req_ready[p] && n < 40) begin
            step();
            #1;
            n++;
        end
        chk(tag, 64'(bus.req_ready), 64'(1) << p);
    endtask

    task automatic read_txn(input int p, input logic [31:0] addr, input logic [7:0] len,
                            input int err_beat, input int ar_delay, input logic [31:0] dbase);
        logic [31:0] sar;
        logic [7:0]  slen;
        logic [7:0]  exp_len;
        logic [31:0] exp_data;
        exp_len = (len > 8'(ML - 1)) ? 8'(ML - 1) : len;
        bus.req_valid[p]        = 1'b1;
        bus.req_wr[p]           = 1'b0;
        bus.req_addr[p*AW +: AW] = addr;
        bus.req_len[p*8 +: 8]   = len;
        bus.req_size[p*3 +: 3]  = 3'd2;
        wait_grant(p, "rd_grant");
        chk("rd_arvalid_grant_cycle", 64'(bus.arvalid), 64'd0);
        step();
        bus.req_valid[p] = 1'b0;
        #1;
        chk("rd_arvalid", 64'(bus.arvalid), 64'd1);
        chk("rd_arid", 64'(bus.arid), 64'(p));
        chk("rd_araddr", 64'(bus.araddr), 64'(addr));
        chk("rd_arlen", 64'(bus.arlen), 64'(exp_len));
        chk("rd_arsize", 64'(bus.arsize), 64'd2);
        chk("rd_arburst", 64'(bus.arburst), 64'd1);
        for (int d = 0; d < ar_delay; d++) begin
            step();
            #1;
            chk("rd_arvalid_hold", 64'(bus.arvalid), 64'd1);
        end
        sar  = bus.araddr;
        slen = bus.arlen;
        bus.arready = 1'b1;
        step();
        bus.arready = 1'b0;
        for (int k = 0; k <= int'(slen); k++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.rvalid = 1'b0;
                #1;
                chk("rd_gap_rvalid", 64'(bus.rsp_rvalid), 64'd0);
                step();
            end
            bus.rvalid = 1'b1;
            bus.rid    = IW'(p);
            bus.rdata  = (dbase != 0) ? dbase + 32'(k) : mem_word(sar + 32'(4 * k));
            bus.rlast  = (k == int'(slen));
            bus.rresp  = (k == err_beat) ? 2'b10 : 2'b00;
            exp_data   = (dbase != 0) ? dbase + 32'(k) : mem_word(addr + 32'(4 * k));
            #1;
            chk("rd_rready", 64'(bus.rready), 64'd1);
            chk("rd_rsp_rvalid", 64'(bus.rsp_rvalid), 64'(1) << p);
            chk("rd_rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_data));
            chk("rd_rsp_rlast", 64'(bus.rsp_rlast), 64'(k == int'(exp_len)));
            chk("rd_rsp_err", 64'(bus.rsp_err), 64'(k == err_beat));
            step();
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
        #1;
        chk("rd_back_idle", 64'(bus.rready), 64'd0);
    endtask

    task automatic write_txn(input int p, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int awd, input int wd, input int bd,
                             input logic [1:0] bresp);
        int aw_cnt = 0;
        int w_cnt  = 0;
        int n      = 0;
        bus.req_valid[p]          = 1'b1;
        bus.req_wr[p]             = 1'b1;
        bus.req_addr[p*AW +: AW]  = addr;
        bus.req_size[p*3 +: 3]    = 3'd2;
        bus.req_wdata[p*DW +: DW] = data;
        bus.req_wstrb[p*4 +: 4]   = strb;
        wait_grant(p, "wr_grant");
        step();
        bus.req_valid[p] = 1'b0;
        bus.req_wr[p]    = 1'b0;
        #1;
        chk("wr_awvalid", 64'(bus.awvalid), 64'd1);
        chk("wr_wvalid", 64'(bus.wvalid), 64'd1);
        chk("wr_awaddr", 64'(bus.awaddr), 64'(addr));
        chk("wr_awid", 64'(bus.awid), 64'(p));
        chk("wr_awlen", 64'(bus.awlen), 64'd0);
        chk("wr_wdata", 64'(bus.wdata), 64'(data));
        chk("wr_wstrb", 64'(bus.wstrb), 64'(strb));
        chk("wr_wid", 64'(bus.wid), 64'(p));
        chk("wr_wlast", 64'(bus.wlast), 64'd1);
        while ((aw_cnt == 0 || w_cnt == 0) && n < 40) begin
            bus.awready = (n >= awd);
            bus.wready  = (n >= wd);
            #1;
            chk("wr_bready_in_send", 64'(bus.bready), 64'd0);
            if (bus.awvalid && bus.awready) aw_cnt++;
            if (bus.wvalid && bus.wready) w_cnt++;
            step();
            n++;
        end
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        #1;
        chk("wr_aw_count", 64'(aw_cnt), 64'd1);
        chk("wr_w_count", 64'(w_cnt), 64'd1);
        chk("wr_awvalid_done", 64'(bus.awvalid), 64'd0);
        chk("wr_wvalid_done", 64'(bus.wvalid), 64'd0);
        chk("wr_bready", 64'(bus.bready), 64'd1);
        for (int d = 0; d < bd; d++) begin
            step();
            #1;
            chk("wr_wdone_early", 64'(bus.rsp_wdone), 64'd0);
        end
        bus.bvalid = 1'b1;
        bus.bid    = IW'(p);
        bus.bresp  = bresp;
        #1;
        chk("wr_wdone", 64'(bus.rsp_wdone), 64'(1) << p);
        chk("wr_err", 64'(bus.rsp_err), 64'(bresp != 2'b00));
        step();
        bus.bvalid = 1'b0;
        bus.bresp  = 2'b00;
        #1;
        chk("wr_wdone_once", 64'(bus.rsp_wdone), 64'd0);
        chk("wr_bready_off", 64'(bus.bready), 64'd0);
    endtask

    int          last_port;
    int          exp_port;
    int          rp;
    int          eb;
    logic [31:0] ra;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn       = 1'b0;
        bus.req_valid = '1;
        bus.req_wr    = '0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.req_size  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.arready   = 1'b0;
        bus.rid       = '0;
        bus.rdata     = '0;
        bus.rresp     = 2'b00;
        bus.rlast     = 1'b0;
        bus.rvalid    = 1'b0;
        bus.awready   = 1'b0;
        bus.wready    = 1'b0;
        bus.bid       = '0;
        bus.bresp     = 2'b00;
        bus.bvalid    = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_arvalid", 64'(bus.arvalid), 64'd0);
        chk("rst_awvalid", 64'(bus.awvalid), 64'd0);
        chk("rst_wvalid", 64'(bus.wvalid), 64'd0);
        chk("rst_rready", 64'(bus.rready), 64'd0);
        chk("rst_bready", 64'(bus.bready), 64'd0);
        bus.req_valid = '0;
        aresetn = 1'b1;
        step();

        read_txn(0, 32'h1FC0_0000, 8'd3, -1, 0, 32'h0000_00A0);
        write_txn(1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 2, 0, 0, 2'b00);

        // Write to 0x100 parked in the response phase while port 0 reads nearby words.
        bus.req_valid[1]         = 1'b1;
        bus.req_wr[1]            = 1'b1;
        bus.req_addr[1*AW +: AW] = 32'h0000_0100;
        wait_grant(1, "hz_wr_grant");
        step();
        bus.req_valid[1] = 1'b0;
        bus.req_wr[1]    = 1'b0;
        bus.awready      = 1'b1;
        bus.wready       = 1'b1;
        step();
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        #1;
        chk("hz_bready", 64'(bus.bready), 64'd1);
        bus.req_valid[0]         = 1'b1;
        bus.req_wr[0]            = 1'b0;
        bus.req_addr[0*AW +: AW] = 32'h0000_0104;
        bus.req_len[0 +: 8]      = 8'd0;
        #1;
        chk("hz_other_word_granted", 64'(bus.req_ready), 64'd1);
        read_txn(0, 32'h0000_0104, 8'd0, -1, 0, 32'h0);
        bus.req_valid[0]         = 1'b1;
        bus.req_addr[0*AW +: AW] = 32'h0000_0100;
        #1;
        chk("hz_blocked", 64'(bus.req_ready), 64'd0);
        repeat (2) begin
            step();
            #1;
            chk("hz_blocked_hold", 64'(bus.req_ready), 64'd0);
        end
        bus.bvalid = 1'b1;
        bus.bid    = IW'(1);
        #1;
        chk("hz_blocked_b_cycle", 64'(bus.req_ready), 64'd0);
        chk("hz_wdone", 64'(bus.rsp_wdone), 64'd2);
        step();
        bus.bvalid = 1'b0;
        #1;
        chk("hz_released", 64'(bus.req_ready), 64'd1);
        read_txn(0, 32'h0000_0100, 8'd1, -1, 0, 32'h0);

        read_txn(0, 32'h0000_3000, 8'd20, 2, 1, 32'h0);

        // Reset dropped while a burst is mid-flight.
        bus.req_valid[0]         = 1'b1;
        bus.req_addr[0*AW +: AW] = 32'h0000_2000;
        bus.req_len[0 +: 8]      = 8'd3;
        wait_grant(0, "mr_grant");
        step();
        bus.req_valid[0] = 1'b0;
        bus.arready      = 1'b1;
        step();
        bus.arready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.rvalid = 1'b1;
            bus.rid    = '0;
            bus.rdata  = 32'(k);
            if (k < 2) step();
        end
        #1;
        chk("mr_beat2_rvalid", 64'(bus.rsp_rvalid), 64'd1);
        aresetn = 1'b0;
        #1;
        chk("mr_rready", 64'(bus.rready), 64'd0);
        chk("mr_arvalid", 64'(bus.arvalid), 64'd0);
        chk("mr_rsp_rvalid", 64'(bus.rsp_rvalid), 64'd0);
        bus.rvalid = 1'b0;
        step();
        aresetn = 1'b1;

        // Both ports hammer reads: grants must alternate starting at port 0.
        bus.req_valid            = '1;
        bus.req_wr               = '0;
        bus.req_addr[0*AW +: AW] = 32'h0000_5000;
        bus.req_addr[1*AW +: AW] = 32'h0000_6000;
        bus.req_len              = '0;
        last_port = NP - 1;
        for (int it = 0; it < 4; it++) begin
            exp_port = (last_port + 1) % NP;
            #1;
            chk("rr_grant", 64'(bus.req_ready), 64'(1) << exp_port);
            step();
            #1;
            chk("rr_arid", 64'(bus.arid), 64'(exp_port));
            bus.arready = 1'b1;
            step();
            bus.arready = 1'b0;
            bus.rvalid  = 1'b1;
            bus.rid     = IW'(exp_port);
            bus.rlast   = 1'b1;
            #1;
            chk("rr_rsp_rvalid", 64'(bus.rsp_rvalid), 64'(1) << exp_port);
            step();
            bus.rvalid = 1'b0;
            bus.rlast  = 1'b0;
            last_port  = exp_port;
        end
        bus.req_valid = '0;
        step();

        for (int it = 0; it < 24; it++) begin
            rp = int'($urandom_range(0, NP - 1));
            ra = {4'h4, 16'($urandom), 10'($urandom), 2'b00};
            eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
            if ($urandom_range(0, 1) == 0) begin
                read_txn(rp, ra, 8'($urandom_range(0, 15)), eb,
                         int'($urandom_range(0, 2)), 32'h0);
            end else begin
                write_txn(rp, ra, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                          ($urandom_range(0, 2) == 0) ? 2'b10 : 2'b00);
            end
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_multi_port_bridge.md
Name: axi_multi_port_bridge

Overview:
- Parametrised successor to the CPU-top AXI boundary. Connects NUM_PORTS simple request/response ports (port 0 = I-fetch, port 1 = D-access, more for future cache refill or uncached units) to one AXI3 master interface.
- Arbitrates round-robin across ports and issues INCR read bursts of up to MAX_LEN beats plus single-beat writes.
- One read and one write may be outstanding at once; a read-after-write address hazard is blocked.

Parameters:
- NUM_PORTS, 2, number of request ports (1..8); the port index is used as the AXI ID.
- ADDR_W, 32, address width.
- DATA_W, 32, AXI data width (32 or 64).
- ID_W, 4, AXI ID width; must satisfy 2^ID_W >= NUM_PORTS.
- MAX_LEN, 8, maximum read burst beats; longer req_len is clamped to MAX_LEN-1.

Ports:
- aclk  in  1  clock; all logic rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_PORTS  per-port request valid; the requester holds all fields stable until req_ready.
- req_ready  out  NUM_PORTS  one-hot grant; the transfer occurs when valid&&ready.
- req_wr  in  NUM_PORTS  1 = write, 0 = read.
- req_addr  in  NUM_PORTS*ADDR_W  byte address, flattened with port i at [i*ADDR_W +: ADDR_W].
- req_len  in  NUM_PORTS*8  read beats minus 1; ignored for writes.
- req_size  in  NUM_PORTS*3  AXI size code.
- req_wdata  in  NUM_PORTS*DATA_W  write data.
- req_wstrb  in  NUM_PORTS*DATA_W/8  write strobes.
- rsp_rvalid  out  NUM_PORTS  read beat valid for port i.
- rsp_rdata  out  DATA_W  read beat data, shared by all ports.
- rsp_rlast  out  1  last beat of the burst.
- rsp_wdone  out  NUM_PORTS  one-cycle write-complete pulse.
- rsp_err  out  1  qualifies rsp_rvalid/rsp_wdone; 1 when resp != OKAY.
- arid/araddr/arlen/arsize/arburst/arvalid  out  ID_W/ADDR_W/8/3/2/1  AXI AR channel.
- arready  in  1  AXI AR ready.
- rid/rdata/rresp/rlast/rvalid  in  ID_W/DATA_W/2/1/1  AXI R channel.
- rready  out  1  AXI R ready.
- awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_W/ADDR_W/8/3/2/1  AXI AW channel.
- awready  in  1  AXI AW ready.
- wid/wdata/wstrb/wlast/wvalid  out  ID_W/DATA_W/DATA_W/8/1/1  AXI W channel.
- wready  in  1  AXI W ready.
- bid/bresp/bvalid  in  ID_W/2/1  AXI B channel.
- bready  out  1  AXI B ready.
- arlock/arcache/arprot, awlock/awcache/awprot  out  2/4/3 each  tied to constant 0.

Behaviour:
- Reset (async on aresetn low, effective immediately, including mid-burst):
  - All valid/ready outputs are 0; req_ready=0; both FSMs go to IDLE; rr_ptr=NUM_PORTS-1; capture registers are 0.
  - In-flight AXI transactions are abandoned; the slave is reset together with the bridge.
- Eligibility: port i is eligible when req_valid[i] and one of:
  - req_wr=0, read FSM is R_IDLE, and there is no hazard;
  - req_wr=1 and write FSM is W_IDLE.
- Hazard: the write FSM is not W_IDLE and req_addr[ADDR_W-1:2] equals the captured write address[ADDR_W-1:2]. A hazarded read waits until the write FSM returns to W_IDLE.
- Arbiter:
  - At most one grant per cycle, to the first eligible port scanning from rr_ptr+1 modulo NUM_PORTS.
  - req_ready is combinational from eligibility. On a grant, rr_ptr <= granted index.
- Read FSM:
  - R_IDLE -> R_AR on grant: capture addr, size, len=min(req_len, MAX_LEN-1), id=i.
  - R_AR: arvalid=1 starting the cycle after the grant; fields come from the capture registers; arburst=INCR. Move to R_DATA on arvalid&&arready.
  - R_DATA: rready=1. Each rvalid beat gives rsp_rvalid[rid]=1 combinationally, with rsp_rdata=rdata, rsp_rlast=rlast, rsp_err=(rresp!=0). Return to R_IDLE on rvalid&&rlast.
  - Beats with rid != captured id are still forwarded to port rid, and are flagged rsp_err=1.
- Write FSM:
  - W_IDLE -> W_SEND on grant: capture addr, size, data, strb, id.
  - W_SEND: awvalid and wvalid both assert the next cycle and drop independently on their own handshakes. awlen=0, wlast=1. Move to W_RESP once both handshakes have occurred; they may complete in the same cycle or in either order.
  - W_RESP: bready=1. On bvalid, pulse rsp_wdone[bid] with rsp_err=(bresp!=0), then go to W_IDLE.
- Simultaneous events:
  - A read grant and write completion in the same cycle are legal.
  - A write FSM leaving W_RESP clears the hazard from the next cycle, not combinationally.
  - A port may hold both a read and a write in flight, issued sequentially.
- Latency: grant at cycle T -> AR/AW valid at T+1. Minimum read turnaround is 3 cycles (grant, AR handshake, first R beat).

Test Plan:
- Single read: port0 reads 0x1FC00000 with len=3; slave has arready=1 and 4 beats 0xA0..0xA3 -> arvalid at T+1, arlen=3, arid=0; rsp_rvalid[0] for 4 beats; rsp_rlast on 0xA3; read FSM back to R_IDLE.
- Round-robin: both ports request reads every cycle -> grant order 0,1,0,1 after reset; arid alternates 0,1.
- Write order: port1 writes 0x80001000, data 0xDEADBEEF, wstrb=0xF; slave takes wready 2 cycles before awready -> exactly one AW and one W; bready only in W_RESP; rsp_wdone[1] pulses once with rsp_err=0.
- Hazard: port1 write to 0x100 pending with bvalid delayed 5 cycles; port0 reads 0x100 and 0x104:
  - read of 0x104 is granted immediately;
  - read of 0x100 is held until the cycle after the B handshake.
- Errors and clamp: port0 issues req_len=20 with MAX_LEN=8 -> arlen=7; rresp=SLVERR on beat 2 -> rsp_err=1 on that beat only.
- Mid-burst reset: aresetn drops in R_DATA beat 2 -> rready, arvalid and rsp_rvalid are 0 in the same cycle; after release, rr_ptr gives port0 first grant.
